perceptron_trainer: RTL and testbench
=====================================

PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

Interface
REQ-001 Parameters: N, default 2, perceptron input count; SAMPLES, default 4, training-set size; ARG_WIDTH, default 8, input width; RES_WIDTH, default 8, result/target width; ERR_WIDTH, default 16, signed error width; FBK_WIDTH, default 16, feedback width.
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  pulse; begins a run when idle.
REQ-005 epochs  input  8  training epoch count, sampled on start.
REQ-006 ld_valid/ld_ready  input/output  1  sample-load handshake.
REQ-007 ld_idx, ld_arg, ld_tgt  input  $clog2(SAMPLES), N*ARG_WIDTH, RES_WIDTH  sample write.
REQ-008 en  output  1  perceptron learning enable.
REQ-009 arg, arg_valid, arg_ready  out/out/in  N*ARG_WIDTH,1,1  forward stream to perceptron.
REQ-010 res, res_valid, res_ready  in/in/out  RES_WIDTH,1,1  forward result.
REQ-011 err, err_valid, err_ready  out/out/in  ERR_WIDTH,1,1  backward error.
REQ-012 fbk, fbk_valid, fbk_ready  in/in/out  N*FBK_WIDTH,1,1  backward feedback, discarded.
REQ-013 busy, done, mismatches  output  1,1,$clog2(SAMPLES+1)  status.

Function
REQ-014 States: IDLE, FWD_ARG, FWD_RES, BWD_ERR, BWD_FBK, EVAL_ARG, EVAL_RES, DONE.
REQ-015 ld_ready=1 only in IDLE and DONE; a load transfer writes sample ld_idx in one cycle.
REQ-016 IDLE/DONE + start: latch epochs, clear mismatches and done, sample index 0; go FWD_ARG if epochs!=0, else EVAL_ARG.
REQ-017 start coincident with ld_valid: load completes, start takes effect; start while busy ignored.
REQ-018 FWD_ARG: en=1, arg_valid=1, arg=sample; transfer -> FWD_RES.
REQ-019 FWD_RES: res_ready=1; transfer latches err = sign-extend(signed({0,tgt}) - signed({0,res})) -> BWD_ERR.
REQ-020 BWD_ERR: err_valid=1; transfer -> BWD_FBK.
REQ-021 BWD_FBK: fbk_ready=1; transfer advances sample; last sample of epoch decrements epoch counter; counter reaching 0 -> EVAL_ARG at index 0, else FWD_ARG (index wraps SAMPLES-1 -> 0).
REQ-022 EVAL_ARG/EVAL_RES: en=0, same forward handshake; err!=0 increments mismatches; after last sample -> DONE.
REQ-023 DONE: done=1 held until next start; busy=1 in all states except IDLE and DONE.
REQ-024 valid outputs SHALL stay asserted with stable payload until the handshake completes; at most one transfer per channel per cycle.
REQ-025 Per-sample latency lower bound: 4 cycles training, 2 cycles evaluation, with zero-wait partner.

Reset
REQ-026 rst_n low: state IDLE; en, arg_valid, res_ready, err_valid, fbk_ready, busy, done = 0; mismatches, err, counters = 0; ld_ready = 1 after release.
REQ-027 Reset mid-run abandons the run immediately; sample storage contents are not reset.

Configuration
REQ-028 TRAINER_EARLY_STOP_EN defined: a training epoch with all errors zero ends training, go EVAL_ARG at end of that epoch.
REQ-029 Undefined: always exactly epochs training epochs.

Structure
REQ-030 Shared package machina_pkg holds width constants and the state enum type.
REQ-031 Sub-module sample_store: SAMPLES-entry register file, one write port, one combinational read port.

Verification
REQ-032 AND set (00/0x00, 0xff00/0x00, 0x00ff/0x00, 0xffff/0xff), epochs=10 -> done=1, mismatches=0.
REQ-033 epochs=0 -> no err_valid pulse; exactly 4 arg transfers with en=0; done.
REQ-034 tgt=0x00, res=0xff -> err=0xFF01 (-255); tgt=0xff, res=0x00 -> err=0x00FF.
REQ-035 Random arg_ready/res_ready/err_ready/fbk_ready stalls -> payloads stable while valid, transfer count 4*(epochs+1) forward.
REQ-036 rst_n low during BWD_ERR -> all outputs at reset values same cycle; new start reruns using retained samples.
REQ-037 With TRAINER_EARLY_STOP_EN, pre-trained zero-error model, epochs=10 -> only 4 training forward transfers.

Source files
------------

// File: rtl/machina_pkg.sv
// Shared width constants and FSM state type for the perceptron trainer.
package machina_pkg;

  localparam int EPOCH_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD_ARG,
    ST_FWD_RES,
    ST_BWD_ERR,
    ST_BWD_FBK,
    ST_EVAL_ARG,
    ST_EVAL_RES,
    ST_DONE
  } state_e;

  // Only these two states accept a start pulse or sample loads.
  function automatic logic is_idle_like(input state_e s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/sample_store.sv
// Training-set register file: one synchronous write port, one combinational read port.
module sample_store #(
  parameter int SAMPLES = 4,
  parameter int ARG_W   = 16,
  parameter int TGT_W   = 8
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [$clog2(SAMPLES)-1:0] i_waddr,
  input  logic [ARG_W-1:0]           i_warg,
  input  logic [TGT_W-1:0]           i_wtgt,
  input  logic [$clog2(SAMPLES)-1:0] i_raddr,
  output logic [ARG_W-1:0]           o_rarg,
  output logic [TGT_W-1:0]           o_rtgt
);

  logic [ARG_W-1:0] r_arg [SAMPLES];
  logic [TGT_W-1:0] r_tgt [SAMPLES];

  // NOTE: the storage has no reset on purpose, so samples survive rst_n and a rerun can reuse them.
  // NOTE: registers are written with non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_arg[i_waddr] <= i_warg;
      r_tgt[i_waddr] <= i_wtgt;
    end
  end

  assign o_rarg = r_arg[i_raddr];
  assign o_rtgt = r_tgt[i_raddr];

endmodule

// File: rtl/perceptron_trainer.sv
// Runs a perceptron through `epochs` training passes (forward + backward) and one evaluation pass.
// Build option: define TRAINER_EARLY_STOP_EN to end training after the first error-free epoch.
module perceptron_trainer
  import machina_pkg::*;
#(
  parameter int N         = 2,
  parameter int SAMPLES   = 4,
  parameter int ARG_WIDTH = 8,
  parameter int RES_WIDTH = 8,
  parameter int ERR_WIDTH = 16,
  parameter int FBK_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [EPOCH_W-1:0]           epochs,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [$clog2(SAMPLES)-1:0]   ld_idx,
  input  logic [N*ARG_WIDTH-1:0]       ld_arg,
  input  logic [RES_WIDTH-1:0]         ld_tgt,
  output logic                         en,
  output logic [N*ARG_WIDTH-1:0]       arg,
  output logic                         arg_valid,
  input  logic                         arg_ready,
  input  logic [RES_WIDTH-1:0]         res,
  input  logic                         res_valid,
  output logic                         res_ready,
  output logic [ERR_WIDTH-1:0]         err,
  output logic                         err_valid,
  input  logic                         err_ready,
  input  logic [N*FBK_WIDTH-1:0]       fbk,
  input  logic                         fbk_valid,
  output logic                         fbk_ready,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(SAMPLES+1)-1:0] mismatches
);

  localparam int IDX_W = $clog2(SAMPLES);
  localparam int MIS_W = $clog2(SAMPLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

  state_e                r_state;
  state_e                w_next_state;
  logic [EPOCH_W-1:0]    r_epochs_left;
  logic [IDX_W-1:0]      r_idx;
  logic [MIS_W-1:0]      r_mism;
  logic [ERR_WIDTH-1:0]  r_err;
  logic [RES_WIDTH-1:0]  w_tgt;
  logic signed [RES_WIDTH:0] w_diff;
  logic [ERR_WIDTH-1:0]  w_err_ext;
  logic                  w_ld_xfer;
  logic                  w_last;
  logic                  w_start;
  logic                  w_train_end;
  logic                  w_unused_fbk;

  assign w_ld_xfer = ld_valid & ld_ready;

  sample_store #(
    .SAMPLES (SAMPLES),
    .ARG_W   (N*ARG_WIDTH),
    .TGT_W   (RES_WIDTH)
  ) u_store (
    .clk     (clk),
    .i_we    (w_ld_xfer),
    .i_waddr (ld_idx),
    .i_warg  (ld_arg),
    .i_wtgt  (ld_tgt),
    .i_raddr (r_idx),
    .o_rarg  (arg),
    .o_rtgt  (w_tgt)
  );

  // Target and result are unsigned; one extra zero bit makes the difference a proper signed value.
  assign w_diff    = $signed({1'b0, w_tgt}) - $signed({1'b0, res});
  assign w_err_ext = {{(ERR_WIDTH-RES_WIDTH-1){w_diff[RES_WIDTH]}}, w_diff};

  assign w_last       = (r_idx == LAST_IDX);
  assign w_start      = start & is_idle_like(r_state);
  assign w_unused_fbk = ^fbk;

`ifdef TRAINER_EARLY_STOP_EN
  logic r_clean;

  assign w_train_end = (r_epochs_left == EPOCH_W'(1)) | r_clean;

  // Tracks whether every error of the current training epoch has been zero so far.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clean <= 1'b0;
    end else if (w_start || (r_state == ST_BWD_FBK && fbk_valid && w_last)) begin
      r_clean <= 1'b1;
    end else if (r_state == ST_FWD_RES && res_valid && w_err_ext != '0) begin
      r_clean <= 1'b0;
    end
  end
`else
  assign w_train_end = (r_epochs_left == EPOCH_W'(1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_next_state = r_state;
    ld_ready     = 1'b0;
    en           = 1'b0;
    arg_valid    = 1'b0;
    res_ready    = 1'b0;
    err_valid    = 1'b0;
    fbk_ready    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        busy     = 1'b0;
        ld_ready = 1'b1;
        done     = (r_state == ST_DONE);
        if (start) w_next_state = (epochs != '0) ? ST_FWD_ARG : ST_EVAL_ARG;
      end
      ST_FWD_ARG: begin
        en        = 1'b1;
        arg_valid = 1'b1;
        if (arg_ready) w_next_state = ST_FWD_RES;
      end
      ST_FWD_RES: begin
        en        = 1'b1;
        res_ready = 1'b1;
        if (res_valid) w_next_state = ST_BWD_ERR;
      end
      ST_BWD_ERR: begin
        en        = 1'b1;
        err_valid = 1'b1;
        if (err_ready) w_next_state = ST_BWD_FBK;
      end
      ST_BWD_FBK: begin
        en        = 1'b1;
        fbk_ready = 1'b1;
        if (fbk_valid) w_next_state = (w_last && w_train_end) ? ST_EVAL_ARG : ST_FWD_ARG;
      end
      ST_EVAL_ARG: begin
        arg_valid = 1'b1;
        if (arg_ready) w_next_state = ST_EVAL_RES;
      end
      ST_EVAL_RES: begin
        res_ready = 1'b1;
        if (res_valid) w_next_state = w_last ? ST_DONE : ST_EVAL_ARG;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_epochs_left <= '0;
      r_idx         <= '0;
      r_mism        <= '0;
      r_err         <= '0;
    end else if (w_start) begin
      r_epochs_left <= epochs;
      r_idx         <= '0;
      r_mism        <= '0;
    end else begin
      case (r_state)
        ST_FWD_RES: begin
          if (res_valid) r_err <= w_err_ext;
        end
        ST_BWD_FBK: begin
          if (fbk_valid) begin
            if (w_last) begin
              r_idx         <= '0;
              r_epochs_left <= r_epochs_left - EPOCH_W'(1);
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        ST_EVAL_RES: begin
          if (res_valid) begin
            r_err <= w_err_ext;
            if (w_err_ext != '0) r_mism <= r_mism + MIS_W'(1);
            if (!w_last) r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign err        = r_err;
  assign mismatches = r_mism;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Self-checking bench: a bench-side partner plays the perceptron; results are checked against a sample/epoch model.
module tb_perceptron_trainer;

  localparam int N         = 2;
  localparam int SAMPLES   = 4;
  localparam int ARG_WIDTH = 8;
  localparam int RES_WIDTH = 8;
  localparam int ERR_WIDTH = 16;
  localparam int FBK_WIDTH = 16;
  localparam int AW        = N*ARG_WIDTH;
  localparam int IDX_W     = $clog2(SAMPLES);
  localparam int MIS_W     = $clog2(SAMPLES + 1);

`ifdef TRAINER_EARLY_STOP_EN
  localparam bit EARLY_STOP = 1'b1;
`else
  localparam bit EARLY_STOP = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [7:0]           epochs;
  logic                 ld_valid;
  logic                 ld_ready;
  logic [IDX_W-1:0]     ld_idx;
  logic [AW-1:0]        ld_arg;
  logic [RES_WIDTH-1:0] ld_tgt;
  logic                 en;
  logic [AW-1:0]        arg;
  logic                 arg_valid;
  logic                 arg_ready;
  logic [RES_WIDTH-1:0] res;
  logic                 res_valid;
  logic                 res_ready;
  logic [ERR_WIDTH-1:0] err;
  logic                 err_valid;
  logic                 err_ready;
  logic [N*FBK_WIDTH-1:0] fbk;
  logic                 fbk_valid;
  logic                 fbk_ready;
  logic                 busy;
  logic                 done;
  logic [MIS_W-1:0]     mismatches;

  perceptron_trainer #(
    .N(N), .SAMPLES(SAMPLES), .ARG_WIDTH(ARG_WIDTH), .RES_WIDTH(RES_WIDTH),
    .ERR_WIDTH(ERR_WIDTH), .FBK_WIDTH(FBK_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .epochs(epochs),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_idx(ld_idx), .ld_arg(ld_arg), .ld_tgt(ld_tgt),
    .en(en), .arg(arg), .arg_valid(arg_valid), .arg_ready(arg_ready),
    .res(res), .res_valid(res_valid), .res_ready(res_ready),
    .err(err), .err_valid(err_valid), .err_ready(err_ready),
    .fbk(fbk), .fbk_valid(fbk_valid), .fbk_ready(fbk_ready),
    .busy(busy), .done(done), .mismatches(mismatches)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Training set as the bench knows it, plus the partner's response to each argument.
  logic [AW-1:0]        s_arg  [SAMPLES];
  logic [RES_WIDTH-1:0] s_tgt  [SAMPLES];
  logic [RES_WIDTH-1:0] s_resp [SAMPLES];

  logic [AW-1:0]        exp_arg[$];
  logic                 exp_en[$];
  logic [ERR_WIDTH-1:0] exp_err[$];
  int                   exp_mism;
  int                   exp_train;

  logic [AW-1:0]        obs_arg[$];
  logic                 obs_en[$];
  logic [ERR_WIDTH-1:0] obs_err[$];
  int                   stab_bad;
  int                   err_pulses;

  bit                   stall_on;
  bit                   res_pend, fbk_pend, res_xfer, fbk_xfer;
  bit                   arg_wait, err_wait;
  logic [RES_WIDTH-1:0] res_hold;
  logic [AW-1:0]        arg_prev;
  logic                 en_prev;
  logic [ERR_WIDTH-1:0] err_prev;

  function automatic logic [RES_WIDTH-1:0] partner_res(input logic [AW-1:0] a);
    for (int k = 0; k < SAMPLES; k++) if (s_arg[k] == a) return s_resp[k];
    return '0;
  endfunction

  // Expected run: `ep` training epochs over all samples, then one evaluation pass.
  task automatic build_model(input int ep);
    int d;
    bit clean;
    exp_arg.delete(); exp_en.delete(); exp_err.delete();
    exp_mism = 0; exp_train = 0;
    for (int e = 0; e < ep; e++) begin
      clean = 1'b1;
      exp_train++;
      for (int s = 0; s < SAMPLES; s++) begin
        d = int'(s_tgt[s]) - int'(partner_res(s_arg[s]));
        exp_arg.push_back(s_arg[s]);
        exp_en.push_back(1'b1);
        exp_err.push_back(ERR_WIDTH'(d));
        if (d != 0) clean = 1'b0;
      end
      if (EARLY_STOP && clean) break;
    end
    for (int s = 0; s < SAMPLES; s++) begin
      d = int'(s_tgt[s]) - int'(partner_res(s_arg[s]));
      exp_arg.push_back(s_arg[s]);
      exp_en.push_back(1'b0);
      if (d != 0) exp_mism++;
    end
  endtask

  function automatic string seq_diff();
    if (obs_arg.size() != exp_arg.size())
      return $sformatf("arg transfers got %0d want %0d", obs_arg.size(), exp_arg.size());
    if (obs_err.size() != exp_err.size())
      return $sformatf("err transfers got %0d want %0d", obs_err.size(), exp_err.size());
    for (int i = 0; i < obs_arg.size(); i++)
      if (obs_arg[i] !== exp_arg[i] || obs_en[i] !== exp_en[i])
        return $sformatf("fwd #%0d got arg=%h en=%b want arg=%h en=%b",
                         i, obs_arg[i], obs_en[i], exp_arg[i], exp_en[i]);
    for (int i = 0; i < obs_err.size(); i++)
      if (obs_err[i] !== exp_err[i])
        return $sformatf("err #%0d got %h want %h", i, obs_err[i], exp_err[i]);
    return "";
  endfunction

  // Perceptron partner: drives inputs on the falling edge, then records what the next rising edge will transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      res_pend = 0; fbk_pend = 0; res_xfer = 0; fbk_xfer = 0; arg_wait = 0; err_wait = 0;
      arg_ready = 1'b0; res_valid = 1'b0; err_ready = 1'b0; fbk_valid = 1'b0;
      res = '0; fbk = '0;
    end else begin
      if (res_xfer) begin res_valid = 1'b0; res_xfer = 0; end
      if (fbk_xfer) begin fbk_valid = 1'b0; fbk_xfer = 0; end
      arg_ready = stall_on ? 1'($urandom_range(0, 1)) : 1'b1;
      err_ready = stall_on ? 1'($urandom_range(0, 1)) : 1'b1;
      if (res_pend && !res_valid) res_valid = stall_on ? 1'($urandom_range(0, 1)) : 1'b1;
      if (fbk_pend && !fbk_valid) fbk_valid = stall_on ? 1'($urandom_range(0, 1)) : 1'b1;
      res = res_valid ? res_hold : RES_WIDTH'($urandom);
      fbk = {$urandom, $urandom};
      #1;
      if (arg_wait && (!arg_valid || arg !== arg_prev || en !== en_prev)) stab_bad++;
      if (err_wait && (!err_valid || err !== err_prev)) stab_bad++;
      arg_wait = arg_valid && !arg_ready;
      err_wait = err_valid && !err_ready;
      arg_prev = arg; en_prev = en; err_prev = err;
      if (err_valid) err_pulses++;
      if (arg_valid && arg_ready) begin
        obs_arg.push_back(arg);
        obs_en.push_back(en);
        res_pend = 1;
        res_hold = partner_res(arg);
      end
      if (res_valid && res_ready) begin res_pend = 0; res_xfer = 1; end
      if (err_valid && err_ready) begin obs_err.push_back(err); fbk_pend = 1; end
      if (fbk_valid && fbk_ready) begin fbk_pend = 0; fbk_xfer = 1; end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic load_all();
    for (int k = 0; k < SAMPLES; k++) begin
      tick();
      ld_valid = 1'b1; ld_idx = IDX_W'(k); ld_arg = s_arg[k]; ld_tgt = s_tgt[k];
    end
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic rand_samples();
    for (int k = 0; k < SAMPLES; k++) begin
      s_arg[k]  = AW'($urandom);
      s_tgt[k]  = RES_WIDTH'($urandom);
      s_resp[k] = ($urandom_range(0, 1) == 1) ? s_tgt[k] : RES_WIDTH'($urandom);
    end
  endtask

  // Starts a run and waits for done; optionally pulses start mid-run or loads one sample with start.
  task automatic run(input int ep, input int budget, input int busy_pulse_at, input int ld_k,
                     output bit timed_out);
    obs_arg.delete(); obs_en.delete(); obs_err.delete();
    stab_bad = 0; err_pulses = 0;
    tick();
    epochs = 8'(ep); start = 1'b1;
    if (ld_k >= 0) begin
      ld_valid = 1'b1; ld_idx = IDX_W'(ld_k); ld_arg = s_arg[ld_k]; ld_tgt = s_tgt[ld_k];
    end
    tick();
    start = 1'b0; ld_valid = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done) break;
      start = (c == busy_pulse_at);
      if (c == busy_pulse_at) epochs = 8'd9;
      tick();
    end
    start = 1'b0;
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    total++;
    if ({ld_ready, busy, done, en, arg_valid, res_ready, err_valid, fbk_ready} !== 8'b1000_0000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 10000000",
               {ld_ready, busy, done, en, arg_valid, res_ready, err_valid, fbk_ready});
    end
    total++;
    if (mismatches !== '0) begin bad++; $display("FAIL reset_mism: got %0d want 0", mismatches); end
    total++;
    if (err !== '0) begin bad++; $display("FAIL reset_err: got %h want 0", err); end
  endtask

  task automatic test_and_set();
    bit to;
    string msg;
    s_arg[0] = 16'h0000; s_tgt[0] = 8'h00;
    s_arg[1] = 16'hff00; s_tgt[1] = 8'h00;
    s_arg[2] = 16'h00ff; s_tgt[2] = 8'h00;
    s_arg[3] = 16'hffff; s_tgt[3] = 8'hff;
    for (int k = 0; k < SAMPLES; k++) s_resp[k] = s_tgt[k];
    load_all();
    build_model(10);
    run(10, 3000, -1, -1, to);
    total++;
    if (to) begin bad++; $display("FAIL and_timeout: done=%b want 1", done); end
    total++;
    if (mismatches !== MIS_W'(0)) begin bad++; $display("FAIL and_mism: got %0d want 0", mismatches); end
    total++;
    msg = seq_diff();
    if (msg != "") begin bad++; $display("FAIL and_seq: %s", msg); end
    total++;
    if (obs_arg.size() != SAMPLES*(exp_train + 1)) begin
      bad++; $display("FAIL and_fwd_count: got %0d want %0d", obs_arg.size(), SAMPLES*(exp_train + 1));
    end
  endtask

  task automatic test_err_sign();
    bit to;
    string msg;
    for (int k = 0; k < SAMPLES; k++) s_arg[k] = AW'(k + 1);
    s_tgt[0] = 8'h00; s_resp[0] = 8'hff;
    s_tgt[1] = 8'hff; s_resp[1] = 8'h00;
    s_tgt[2] = 8'h80; s_resp[2] = 8'h80;
    s_tgt[3] = 8'h01; s_resp[3] = 8'h02;
    load_all();
    build_model(1);
    run(1, 1000, -1, -1, to);
    total++;
    if (to) begin bad++; $display("FAIL sign_timeout: done=%b want 1", done); end
    total++;
    if (obs_err.size() < 1 || obs_err[0] !== 16'hFF01) begin
      bad++; $display("FAIL sign_neg: got %h want ff01", (obs_err.size() > 0) ? obs_err[0] : 16'h0);
    end
    total++;
    if (obs_err.size() < 2 || obs_err[1] !== 16'h00FF) begin
      bad++; $display("FAIL sign_pos: got %h want 00ff", (obs_err.size() > 1) ? obs_err[1] : 16'h0);
    end
    total++;
    msg = seq_diff();
    if (msg != "") begin bad++; $display("FAIL sign_seq: %s", msg); end
    total++;
    if (mismatches !== MIS_W'(exp_mism)) begin
      bad++; $display("FAIL sign_mism: got %0d want %0d", mismatches, exp_mism);
    end
  endtask

  task automatic test_zero_epochs();
    bit to;
    int en_ones;
    string msg;
    rand_samples();
    load_all();
    build_model(0);
    run(0, 500, -1, -1, to);
    en_ones = 0;
    foreach (obs_en[i]) if (obs_en[i]) en_ones++;
    total++;
    if (to) begin bad++; $display("FAIL zero_timeout: done=%b want 1", done); end
    total++;
    if (err_pulses != 0) begin bad++; $display("FAIL zero_err_valid: got %0d cycles want 0", err_pulses); end
    total++;
    if (obs_arg.size() != SAMPLES) begin
      bad++; $display("FAIL zero_fwd_count: got %0d want %0d", obs_arg.size(), SAMPLES);
    end
    total++;
    if (en_ones != 0) begin bad++; $display("FAIL zero_en: got %0d en=1 transfers want 0", en_ones); end
    total++;
    msg = seq_diff();
    if (msg != "") begin bad++; $display("FAIL zero_seq: %s", msg); end
  endtask

  task automatic test_random_stalls();
    bit to;
    int ep;
    string msg;
    stall_on = 1'b1;
    for (int it = 0; it < 3; it++) begin
      rand_samples();
      ep = $urandom_range(1, 4);
      load_all();
      build_model(ep);
      run(ep, 4000, -1, -1, to);
      total++;
      if (to) begin bad++; $display("FAIL stall_timeout[%0d]: done=%b want 1", it, done); end
      total++;
      msg = seq_diff();
      if (msg != "") begin bad++; $display("FAIL stall_seq[%0d]: %s", it, msg); end
      total++;
      if (stab_bad != 0) begin bad++; $display("FAIL stall_stable[%0d]: got %0d violations want 0", it, stab_bad); end
      total++;
      if (obs_arg.size() != SAMPLES*(exp_train + 1)) begin
        bad++; $display("FAIL stall_fwd_count[%0d]: got %0d want %0d", it, obs_arg.size(), SAMPLES*(exp_train + 1));
      end
      total++;
      if (mismatches !== MIS_W'(exp_mism)) begin
        bad++; $display("FAIL stall_mism[%0d]: got %0d want %0d", it, mismatches, exp_mism);
      end
    end
    stall_on = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit to;
    bit seen;
    string msg;
    rand_samples();
    s_resp[0] = s_tgt[0] ^ 8'h5a;
    load_all();
    tick();
    epochs = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (err_valid) begin seen = 1; break; end
      tick();
    end
    total++;
    if (!seen) begin bad++; $display("FAIL midrst_reach: err_valid=%b want 1", err_valid); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({en, arg_valid, res_ready, err_valid, fbk_ready, busy, done} !== 7'b0) begin
      bad++; $display("FAIL midrst_ctrl: got %b want 0000000",
                      {en, arg_valid, res_ready, err_valid, fbk_ready, busy, done});
    end
    total++;
    if (mismatches !== '0 || err !== '0) begin
      bad++; $display("FAIL midrst_regs: got mism=%0d err=%h want 0 0", mismatches, err);
    end
    tick();
    rst_n = 1'b1;
    build_model(2);
    run(2, 2000, -1, -1, to);
    total++;
    if (to) begin bad++; $display("FAIL midrst_timeout: done=%b want 1", done); end
    total++;
    msg = seq_diff();
    if (msg != "") begin bad++; $display("FAIL midrst_seq: %s", msg); end
    total++;
    if (mismatches !== MIS_W'(exp_mism)) begin
      bad++; $display("FAIL midrst_mism: got %0d want %0d", mismatches, exp_mism);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    string msg;
    rand_samples();
    load_all();
    build_model(2);
    run(2, 2000, 3, -1, to);
    total++;
    if (to) begin bad++; $display("FAIL b2b_busy_timeout: done=%b want 1", done); end
    total++;
    msg = seq_diff();
    if (msg != "") begin bad++; $display("FAIL b2b_busy_seq: %s", msg); end
    s_arg[2]  = ~s_arg[2];
    s_tgt[2]  = s_tgt[2] + 8'd17;
    s_resp[2] = s_tgt[2] ^ 8'h01;
    build_model(1);
    run(1, 2000, -1, 2, to);
    total++;
    if (to) begin bad++; $display("FAIL b2b_ld_timeout: done=%b want 1", done); end
    total++;
    msg = seq_diff();
    if (msg != "") begin bad++; $display("FAIL b2b_ld_seq: %s", msg); end
    total++;
    if (mismatches !== MIS_W'(exp_mism)) begin
      bad++; $display("FAIL b2b_ld_mism: got %0d want %0d", mismatches, exp_mism);
    end
    total++;
    if (!done || busy || !ld_ready) begin
      bad++; $display("FAIL b2b_done_hold: got done=%b busy=%b ld_ready=%b want 1 0 1", done, busy, ld_ready);
    end
  endtask

  initial begin
    total = 0; bad = 0; stall_on = 1'b0;
    stab_bad = 0; err_pulses = 0;
    rst_n = 1'b0; start = 1'b0; epochs = '0;
    ld_valid = 1'b0; ld_idx = '0; ld_arg = '0; ld_tgt = '0;
    test_reset();
    test_and_set();
    test_err_sign();
    test_zero_epochs();
    test_random_stalls();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
